// File: rtl/debug_cmd_if.sv
// Abstract-command request/response channel between the debug module
// front end (master) and the command engine (slave).
`ifndef XLEN
`define XLEN 64
`endif

interface debug_cmd_if #(
    parameter int XLEN = `XLEN
) ();
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [15:0]     cmd_regno_i;
    logic            cmd_write_i;
    logic [XLEN-1:0] cmd_wdata_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rdata_o;
    logic [2:0]      rsp_err_o;

    modport slave (
        input  cmd_valid_i, cmd_regno_i, cmd_write_i, cmd_wdata_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output cmd_valid_i, cmd_regno_i, cmd_write_i, cmd_wdata_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/debug_cmd_engine.sv
// Debug abstract-command engine: executes single register accesses
// (CSR / integer GPR / FP GPR) on a halted hart and handles halt/resume
// run control towards the core.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command, ready when no resume is pending
// ACCESS | index driven, write strobe pulses for writes
// SAMPLE | index still driven, read data captured at end of cycle
// RESP   | response held until the requester takes it
`ifndef XLEN
`define XLEN 64
`endif

module debug_cmd_engine #(
    parameter int XLEN = `XLEN
) (
    input  logic            clk_i,
    input  logic            srstn_i,
    debug_cmd_if.slave      bus,
    input  logic            dm_haltreq_i,
    input  logic            dm_resumereq_i,
    output logic            dm_halted_o,
    output logic            dm_running_o,
    output logic            dm_resumeack_o,
    output logic [11:0]     csrindex_o,
    output logic            csrwr_o,
    output logic [XLEN-1:0] csrwdata_o,
    input  logic [XLEN-1:0] csrrdata_i,
    output logic [4:0]      igprindex_o,
    output logic            igprwr_o,
    output logic [XLEN-1:0] igprwdata_o,
    input  logic [XLEN-1:0] igprrdata_i,
    output logic [4:0]      fgprindex_o,
    output logic            fgprwr_o,
    output logic [XLEN-1:0] fgprwdata_o,
    input  logic [XLEN-1:0] fgprrdata_i,
    output logic            haltreq_o,
    output logic            resumereq_o,
    input  logic            halted_i,
    input  logic            run_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, SAMPLE, RESP} state_t;
    typedef enum logic [1:0] {TGT_CSR, TGT_IGPR, TGT_FGPR, TGT_NONE} tgt_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_NOTSUP  = 3'd2;
    localparam logic [2:0] ERR_HALTRES = 3'd4;

    state_t          state_q, state_d;
    tgt_t            tgt_in, tgt_q;
    logic [2:0]      err_in, err_q;
    logic [11:0]     regno_q;
    logic            write_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            ready_en_q;
    logic            haltreq_q, halted_q, run_q;
    logic            resumereq_q, resumeack_q;
    logic            cmd_ready;
    logic            accept;
    logic            resume_ok;

    // ready is held low through reset and for the release edge itself
    assign cmd_ready = ready_en_q && (state_q == IDLE) && !resumereq_q;
    assign accept    = bus.cmd_valid_i && cmd_ready;
    assign resume_ok = dm_resumereq_i && halted_i && !dm_haltreq_i && (state_q == IDLE);

    assign haltreq_o      = haltreq_q;
    assign resumereq_o    = resumereq_q;
    assign dm_halted_o    = halted_q;
    assign dm_running_o   = run_q;
    assign dm_resumeack_o = resumeack_q;

    // classify the incoming register number and its error code
    always_comb begin
        tgt_in = TGT_NONE;
        if (bus.cmd_regno_i[15:12] == 4'h0)
            tgt_in = TGT_CSR;
        else if (bus.cmd_regno_i[15:5] == 11'h080)
            tgt_in = TGT_IGPR;
        else if (bus.cmd_regno_i[15:5] == 11'h081)
            tgt_in = TGT_FGPR;

        if (!halted_i)
            err_in = ERR_HALTRES;
        else if (tgt_in == TGT_NONE)
            err_in = ERR_NOTSUP;
        else
            err_in = ERR_NONE;
    end

    // command FSM state register
    always_ff @(posedge clk_i) begin
        if (!srstn_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next state and core-port / response drive
    always_comb begin
        state_d         = state_q;
        bus.cmd_ready_o = cmd_ready;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_rdata_o = '0;
        bus.rsp_err_o   = ERR_NONE;
        csrindex_o      = '0;
        csrwr_o         = 1'b0;
        csrwdata_o      = '0;
        igprindex_o     = '0;
        igprwr_o        = 1'b0;
        igprwdata_o     = '0;
        fgprindex_o     = '0;
        fgprwr_o        = 1'b0;
        fgprwdata_o     = '0;

        if (state_q == ACCESS || state_q == SAMPLE) begin
            case (tgt_q)
                TGT_CSR:  csrindex_o  = regno_q;
                TGT_IGPR: igprindex_o = regno_q[4:0];
                TGT_FGPR: fgprindex_o = regno_q[4:0];
                default:  ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (err_in != ERR_NONE) ? RESP : ACCESS;
            end
            ACCESS: begin
                if (write_q) begin
                    case (tgt_q)
                        TGT_CSR:  begin csrwr_o  = 1'b1; csrwdata_o  = wdata_q; end
                        TGT_IGPR: begin igprwr_o = 1'b1; igprwdata_o = wdata_q; end
                        TGT_FGPR: begin fgprwr_o = 1'b1; fgprwdata_o = wdata_q; end
                        default:  ;
                    endcase
                end
                state_d = SAMPLE;
            end
            SAMPLE: begin
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_rdata_o = rdata_q;
                bus.rsp_err_o   = err_q;
                if (bus.rsp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // command latch and read-data capture
    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            ready_en_q <= 1'b0;
            regno_q    <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            err_q      <= ERR_NONE;
            tgt_q      <= TGT_NONE;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                regno_q <= bus.cmd_regno_i[11:0];
                write_q <= bus.cmd_write_i;
                wdata_q <= bus.cmd_wdata_i;
                err_q   <= err_in;
                tgt_q   <= tgt_in;
                rdata_q <= '0;
            end else if (state_q == SAMPLE && !write_q) begin
                case (tgt_q)
                    TGT_CSR:  rdata_q <= csrrdata_i;
                    TGT_IGPR: rdata_q <= igprrdata_i;
                    TGT_FGPR: rdata_q <= fgprrdata_i;
                    default:  rdata_q <= '0;
                endcase
            end
        end
    end

    // run control: status sampling and resume request/acknowledge
    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            haltreq_q   <= 1'b0;
            halted_q    <= 1'b0;
            run_q       <= 1'b0;
            resumereq_q <= 1'b0;
            resumeack_q <= 1'b0;
        end else begin
            haltreq_q <= dm_haltreq_i;
            halted_q  <= halted_i;
            run_q     <= run_i;
            if (resume_ok) begin
                resumereq_q <= 1'b1;
                resumeack_q <= 1'b0;
            end else if (resumereq_q && run_i) begin
                resumereq_q <= 1'b0;
                resumeack_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// Bench for debug_cmd_engine: directed and randomized commands checked
// against a range-based reference model, plus run-control and reset cases.
module tb_debug_cmd_engine;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic srstn = 1'b0;
    debug_cmd_if #(.XLEN(XLEN)) bus ();

    logic            dm_haltreq, dm_resumereq;
    logic            dm_halted, dm_running, dm_resumeack;
    logic [11:0]     csrindex;
    logic            csrwr;
    logic [XLEN-1:0] csrwdata, csrrdata;
    logic [4:0]      igprindex, fgprindex;
    logic            igprwr, fgprwr;
    logic [XLEN-1:0] igprwdata, fgprwdata, igprrdata, fgprrdata;
    logic            haltreq, resumereq, halted, run;

    int checks = 0;
    int errors = 0;

    debug_cmd_engine #(.XLEN(XLEN)) dut (
        .clk_i(clk), .srstn_i(srstn), .bus(bus),
        .dm_haltreq_i(dm_haltreq), .dm_resumereq_i(dm_resumereq),
        .dm_halted_o(dm_halted), .dm_running_o(dm_running), .dm_resumeack_o(dm_resumeack),
        .csrindex_o(csrindex), .csrwr_o(csrwr), .csrwdata_o(csrwdata), .csrrdata_i(csrrdata),
        .igprindex_o(igprindex), .igprwr_o(igprwr), .igprwdata_o(igprwdata), .igprrdata_i(igprrdata),
        .fgprindex_o(fgprindex), .fgprwr_o(fgprwr), .fgprwdata_o(fgprwdata), .fgprrdata_i(fgprrdata),
        .haltreq_o(haltreq), .resumereq_o(resumereq), .halted_i(halted), .run_i(run)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // target: 0 unsupported, 1 CSR, 2 integer GPR, 3 FP GPR
    task automatic ref_cmd(input logic [15:0] r, input logic hlt,
                           output logic [2:0] err, output int tgt, output int idx);
        int v;
        v = int'(r);
        tgt = 0;
        idx = 0;
        if (v <= 'h0FFF) begin
            tgt = 1; idx = v;
        end else if (v >= 'h1000 && v <= 'h101F) begin
            tgt = 2; idx = v - 'h1000;
        end else if (v >= 'h1020 && v <= 'h103F) begin
            tgt = 3; idx = v - 'h1020;
        end
        if (!hlt)          err = 3'd4;
        else if (tgt == 0) err = 3'd2;
        else               err = 3'd0;
    endtask

    task automatic do_cmd(input string tag, input logic [15:0] r, input logic wr,
                          input logic [63:0] wd, input logic [63:0] rdv,
                          input logic hlt, input int hold, input logic drop_halt);
        logic [2:0]  exp_err;
        logic [63:0] exp_rd;
        int tgt, idx, exp_lat, lat, sc, si, sf, got_idx;
        ref_cmd(r, hlt, exp_err, tgt, idx);
        exp_lat = (exp_err != 3'd0) ? 1 : 3;
        exp_rd  = 64'd0;
        if (!wr && exp_err == 3'd0)
            exp_rd = (tgt == 1) ? ~rdv : (tgt == 2) ? rdv : {rdv[31:0], rdv[63:32]};
        lat = 0; sc = 0; si = 0; sf = 0;

        @(negedge clk);
        halted          = hlt;
        igprrdata       = rdv;
        csrrdata        = ~rdv;
        fgprrdata       = {rdv[31:0], rdv[63:32]};
        bus.cmd_regno_i = r;
        bus.cmd_write_i = wr;
        bus.cmd_wdata_i = wd;
        bus.cmd_valid_i = 1'b1;
        bus.rsp_ready_i = 1'b0;
        #1 chk({tag, "_ready"}, 64'(bus.cmd_ready_o), 64'(1));
        @(posedge clk);
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            bus.cmd_valid_i = 1'b0;
            if (bus.rsp_valid_o) lat = n;
            if (exp_err == 3'd0 && (n == 1 || n == 2)) begin
                got_idx = (tgt == 1) ? int'(csrindex) : (tgt == 2) ? int'(igprindex) : int'(fgprindex);
                chk({tag, "_idx"}, 64'(got_idx), 64'(idx));
            end
            if (csrwr) begin
                sc++;
                chk({tag, "_csrwd"}, csrwdata, wd);
            end
            if (igprwr) begin
                si++;
                chk({tag, "_igwd"}, igprwdata, wd);
            end
            if (fgprwr) begin
                sf++;
                chk({tag, "_fgwd"}, fgprwdata, wd);
            end
            if (drop_halt && n == 1) halted = 1'b0;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_csrwr_n"}, 64'(sc), 64'((wr && exp_err == 3'd0 && tgt == 1) ? 1 : 0));
        chk({tag, "_igwr_n"},  64'(si), 64'((wr && exp_err == 3'd0 && tgt == 2) ? 1 : 0));
        chk({tag, "_fgwr_n"},  64'(sf), 64'((wr && exp_err == 3'd0 && tgt == 3) ? 1 : 0));
        chk({tag, "_err"}, 64'(bus.rsp_err_o), 64'(exp_err));
        chk({tag, "_rdata"}, bus.rsp_rdata_o, exp_rd);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 64'(bus.rsp_valid_o), 64'(1));
            chk({tag, "_hold_d"}, bus.rsp_rdata_o, exp_rd);
            chk({tag, "_hold_e"}, 64'(bus.rsp_err_o), 64'(exp_err));
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk({tag, "_done"}, 64'(bus.rsp_valid_o), 64'(0));
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] bnd [6];
        bnd = '{16'h0FFF, 16'h1000, 16'h101F, 16'h1020, 16'h103F, 16'h1040};
        bus.cmd_valid_i = 1'b0;
        bus.cmd_regno_i = '0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        dm_haltreq = 1'b0; dm_resumereq = 1'b0;
        halted = 1'b1; run = 1'b0;
        csrrdata = '0; igprrdata = '0; fgprrdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bus.cmd_ready_o), 64'(0));
        chk("rst_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("rst_ack", 64'(dm_resumeack), 64'(0));
        srstn = 1'b1;
        @(negedge clk);
        chk("rel_ready", 64'(bus.cmd_ready_o), 64'(1));

        do_cmd("gpr_rd", 16'h1005, 1'b0, 64'd0, 64'hDEAD_BEEF, 1'b1, 0, 1'b0);
        do_cmd("csr_wr", 16'h0300, 1'b1, 64'h8, 64'h1234, 1'b1, 0, 1'b0);
        do_cmd("nohalt", 16'h1005, 1'b1, 64'h55, 64'h1, 1'b0, 0, 1'b0);
        do_cmd("notsup", 16'h2000, 1'b0, 64'h0, 64'h2, 1'b1, 0, 1'b0);
        do_cmd("x0_wr", 16'h1000, 1'b1, 64'hABCD, 64'h3, 1'b1, 0, 1'b0);
        do_cmd("fpr_rd", 16'h103F, 1'b0, 64'h0, 64'hCAFE_F00D_0123_4567, 1'b1, 5, 1'b0);
        do_cmd("drop", 16'h1011, 1'b0, 64'h0, 64'h9999, 1'b1, 0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: r = 16'($urandom_range(0, 'h0FFF));
                1: r = 16'h1000 + 16'($urandom_range(0, 31));
                2: r = 16'h1020 + 16'($urandom_range(0, 31));
                3: r = 16'($urandom_range('h1040, 'hFFFF));
                default: r = bnd[$urandom_range(0, 5)];
            endcase
            do_cmd("rnd", r, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                   {$urandom, $urandom}, ($urandom_range(0, 3) != 0), $urandom_range(0, 3), 1'b0);
        end

        // honoured resume
        @(negedge clk);
        halted = 1'b1; run = 1'b0; dm_haltreq = 1'b0; dm_resumereq = 1'b1;
        @(negedge clk);
        dm_resumereq = 1'b0;
        chk("res_req", 64'(resumereq), 64'(1));
        chk("res_ack0", 64'(dm_resumeack), 64'(0));
        chk("res_busy", 64'(bus.cmd_ready_o), 64'(0));
        repeat (3) begin
            @(negedge clk);
            chk("res_hold", 64'(resumereq), 64'(1));
        end
        run = 1'b1; halted = 1'b0;
        @(negedge clk);
        chk("res_clr", 64'(resumereq), 64'(0));
        chk("res_ack1", 64'(dm_resumeack), 64'(1));
        chk("running", 64'(dm_running), 64'(1));
        chk("halted0", 64'(dm_halted), 64'(0));

        // resume while halt requested is ignored
        halted = 1'b1; run = 1'b0; dm_haltreq = 1'b1; dm_resumereq = 1'b1;
        #1 chk("hreq_lag", 64'(haltreq), 64'(0));
        @(negedge clk);
        dm_resumereq = 1'b0;
        chk("ign_req", 64'(resumereq), 64'(0));
        chk("ign_ack", 64'(dm_resumeack), 64'(1));
        chk("hreq", 64'(haltreq), 64'(1));
        chk("halted1", 64'(dm_halted), 64'(1));

        // reset during SAMPLE
        bus.cmd_regno_i = 16'h1003; bus.cmd_write_i = 1'b0; bus.cmd_valid_i = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("smp_idx", 64'(igprindex), 64'(3));
        srstn = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("mrst_ready", 64'(bus.cmd_ready_o), 64'(0));
        chk("mrst_idx", 64'(igprindex), 64'(0));
        chk("mrst_rdata", bus.rsp_rdata_o, 64'(0));
        chk("mrst_err", 64'(bus.rsp_err_o), 64'(0));
        chk("mrst_hreq", 64'(haltreq), 64'(0));
        chk("mrst_halted", 64'(dm_halted), 64'(0));
        chk("mrst_ack", 64'(dm_resumeack), 64'(0));
        chk("mrst_rreq", 64'(resumereq), 64'(0));
        srstn = 1'b1;
        @(negedge clk);
        chk("mrel_ready", 64'(bus.cmd_ready_o), 64'(1));
        do_cmd("post_rst", 16'h1003, 1'b0, 64'h0, 64'h7777, 1'b1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
